// File: rtl/boss_hp_tx.sv
// boss_hp_tx: transmit side of the boss-HP link between the two player boards.
// Watches the local boss HP and sends it to the UART transmitter as a 3-byte
// frame (HEADER, {1'b0,hp}, HEADER^{1'b0,hp}) over a valid/ready byte handshake.
// A frame is followed by GAP_CYCLES idle clocks.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   game_start   single-cycle pulse, forces one frame
//   game_active  game state; frames launch only while it equals 1
//   boss_hp      local boss HP (0..100)
//   tx_ready     UART transmitter can accept a byte
//   tx_valid     tx_data holds a byte to send (registered)
//   tx_data      byte to send (registered)
//   busy         frame or post-frame gap in progress
//
// Optional feature: define BOSS_HP_TX_HEARTBEAT_EN to resend an unchanged HP
// every HEARTBEAT_CYCLES clocks while game_active==1.
module boss_hp_tx #(
  parameter logic [7:0] HEADER           = 8'hB5,
  parameter int         GAP_CYCLES       = 16,
  parameter int         HEARTBEAT_CYCLES = 65_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_start,
  input  logic [1:0] game_active,
  input  logic [6:0] boss_hp,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       busy
);

  localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_HP, S_CHK, S_GAP} state_t;

  state_t        r_state;
  logic          r_tx_valid;
  logic [7:0]    r_tx_data;
  logic          r_busy;
  logic [6:0]    r_last_sent;
  logic [6:0]    r_snap;
  logic          r_force;
  logic          r_act_q;
  logic [GW-1:0] r_gap_cnt;

  logic w_active, w_enter, w_pending, w_launch, w_hb_hit, w_force_set;

  assign w_active  = (game_active == 2'd1);
  assign w_enter   = w_active && !r_act_q;
  assign w_pending = w_active && ((boss_hp != r_last_sent) || r_force);
  assign w_launch  = (r_state == S_IDLE) && w_pending;
  assign w_force_set = game_start || w_enter || w_hb_hit;

`ifdef BOSS_HP_TX_HEARTBEAT_EN
  localparam logic [26:0] HB_LAST = 27'(HEARTBEAT_CYCLES - 1);
  logic [26:0] r_hb_cnt;

  assign w_hb_hit = w_active && (r_hb_cnt == HB_LAST);

  always_ff @(posedge clk) begin
    if (rst || !w_active || w_launch || w_hb_hit) r_hb_cnt <= '0;
    else                                          r_hb_cnt <= r_hb_cnt + 27'd1;
  end
`else
  logic w_unused_hb;
  assign w_hb_hit    = 1'b0;
  assign w_unused_hb = (HEARTBEAT_CYCLES == 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= 8'h00;
      r_busy      <= 1'b0;
      r_last_sent <= 7'h7F;
      r_snap      <= 7'h00;
      r_force     <= 1'b0;
      r_act_q     <= 1'b0;
      r_gap_cnt   <= '0;
    end else begin
      r_act_q <= w_active;
      // Launch wins over a same-cycle set: the frame being launched already
      // carries the current HP, so the request is satisfied by it.
      if (w_launch)         r_force <= 1'b0;
      else if (w_force_set) r_force <= 1'b1;

      case (r_state)
        S_IDLE: if (w_pending) begin
          r_snap     <= boss_hp;
          r_state    <= S_HDR;
          r_tx_valid <= 1'b1;
          r_tx_data  <= HEADER;
          r_busy     <= 1'b1;
        end
        S_HDR: if (tx_ready) begin
          r_state   <= S_HP;
          r_tx_data <= {1'b0, r_snap};
        end
        S_HP: if (tx_ready) begin
          r_state   <= S_CHK;
          r_tx_data <= HEADER ^ {1'b0, r_snap};
        end
        S_CHK: if (tx_ready) begin
          r_tx_valid  <= 1'b0;
          r_last_sent <= r_snap;
          if (GAP_CYCLES == 0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= GAP_LOAD;
            r_state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_data;
  assign busy     = r_busy;

endmodule
